eth_rx_arbiter: RTL
===================

Name: eth_rx_arbiter

Overview:
Frame-level round-robin arbiter that shares the single ip_parser between NUM_PORTS Ethernet receive byte streams, each fed from its own RX FIFO. It grants one requester for a whole frame, from its first byte to its eof. It forwards that frame's bytes to the parser's eth_* inputs with one registered cycle of latency. A stall watchdog aborts a frame that stops mid-way, so the parser always sees a terminated frame.

Parameters:
NUM_PORTS, 2, number of requesting byte streams (2..8)
TIMEOUT_CYCLES, 4096, consecutive no-accept cycles in STREAM before the frame is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_data  in  [NUM_PORTS][7:0]  per-port byte (byte_t)
req_valid  in  NUM_PORTS  per-port byte valid
req_eof  in  NUM_PORTS  byte is last of frame
req_err  in  NUM_PORTS  frame error flag, qualified with eof
req_ready  out  NUM_PORTS  byte accepted when valid&ready
eth_data_in  out  8  byte to ip_parser
eth_byte_valid  out  1  byte strobe to ip_parser
eth_eof  out  1  end of frame to ip_parser
eth_err  out  1  error to ip_parser
grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port
busy  out  1  high in STREAM or DRAIN
frame_cnt  out  16  frames forwarded (optional feature)
abort_cnt  out  16  frames aborted by watchdog (optional feature)

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr pointer = NUM_PORTS-1, so port 0 is granted first; timeout counter 0.
- Handshake: per-port valid/ready, no combinational path from req_valid to req_ready. ip_parser applies no backpressure.
- IDLE: req_ready all 0. If any req_valid, pick the first valid port searching from pointer+1 with wrap. Register grant_idx and the pointer, then go to STREAM next cycle. Idle frames do not consume a slot.
- STREAM: req_ready[grant_idx]=1, all others 0.
  - On accept, the next cycle drives eth_data_in=req_data, eth_byte_valid=1, eth_eof=req_eof, eth_err=req_eof&req_err.
  - Accept with eof: go to IDLE, giving a guaranteed 1-cycle gap between frames.
  - Cycles with no accept: eth_byte_valid=0. Valid bytes may arrive sparsely, e.g. 1 in 4 cycles.
- Watchdog: counter clears on every accept and increments each STREAM cycle without one. When it reaches TIMEOUT_CYCLES-1:
  - next cycle emits eth_byte_valid=1, eth_data_in=8'h00, eth_eof=1, eth_err=1;
  - state goes to DRAIN.
- DRAIN: req_ready[grant_idx]=1. Accepted bytes are discarded, with no eth_byte_valid. Accept with eof returns to IDLE. No timeout applies in DRAIN.
- eth_eof and eth_err are single-cycle pulses, only ever asserted together with eth_byte_valid.
- Ports not granted are never dropped; they wait.
- Reset mid-frame: immediate return to IDLE, outputs 0. The parser is reset by the same reset.
- grant_idx holds its value in IDLE.

Optional Feature:
Macro ARB_FRAME_STATS_EN.
- Defined: frame_cnt increments on every forwarded eth_eof, including aborts. abort_cnt increments on each watchdog abort. Both 16-bit, wrap at 16'hFFFF->0, cleared by reset.
- Undefined: no counter logic; frame_cnt and abort_cnt are tied to 0.

Decomposition:
- Shared project package, which already holds byte_t and byte_array_t, gains:
  - arb_state_t enum {IDLE, STREAM, DRAIN};
  - ARB_MAX_PORTS=8.
- One sub-module, rr_arbiter:
  - combinational round-robin pick from a NUM_PORTS request vector and pointer;
  - outputs a one-hot grant and an index.
- The FSM, watchdog and output register stay in eth_rx_arbiter.

Test Plan (NUM_PORTS=2, TIMEOUT_CYCLES=16, bytes paced 1 per 4 cycles):
- Port 0 alone sends a 20-byte header plus 55-byte payload to IP 0xC0A80101 -> 75 eth_byte_valid pulses in order with eth_eof on byte 75, grant_idx=0, ip_parser ip_eof with no ip_err.
- Both ports have a frame pending at the same cycle after reset -> port 0's frame is forwarded completely, then port 1's. No interleaving; at least 1 idle cycle between frames.
- Port 0 frames back-to-back while port 1 is pending -> order is p0, p1, p0 (round-robin fairness).
- Port 1 stalls after byte 10 for 16 cycles -> abort beat (00, eof=1, err=1) seen and ip_err asserted. Remaining p1 bytes are drained with no eth_byte_valid; then a p0 frame is forwarded cleanly.
- Last byte of a frame with req_err=1 -> eth_eof=1 and eth_err=1 on the same beat, ip_err asserted.
- rst pulsed mid-frame on byte 30 -> all outputs 0 immediately; the next frame starts from port 0. With ARB_FRAME_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/eth_rx_arbiter_pkg.sv
// Shared project package: byte types plus the frame arbiter
// state encoding and port-count limit.
package eth_rx_arbiter_pkg;

    typedef logic [7:0] byte_t;

    localparam int ARB_MAX_PORTS = 8;

    typedef byte_t [ARB_MAX_PORTS-1:0] byte_array_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/eth_rx_arbiter_rr.sv
// Combinational round-robin pick: first requester after the
// pointer, wrapping, as a one-hot grant plus its index.
module rr_arbiter
    import eth_rx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        idx
);

    // Scan from ptr+1 around to ptr itself; first hit wins.
    always_comb begin
        int  p;
        logic hit;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        p   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            p = (int'(ptr) + k) % NUM_PORTS;
            if (!hit && req[p]) begin
                hit    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/eth_rx_arbiter.sv
// Frame-level round-robin arbiter feeding ip_parser, with stall watchdog.
// Optional frame/abort counters enabled by defining ARB_FRAME_STATS_EN.
module eth_rx_arbiter
    import eth_rx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0][7:0] req_data,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS-1:0]      req_eof,
    input  logic [NUM_PORTS-1:0]      req_err,
    output logic [NUM_PORTS-1:0]      req_ready,
    output logic [7:0]                eth_data_in,
    output logic                      eth_byte_valid,
    output logic                      eth_eof,
    output logic                      eth_err,
    output logic [IW-1:0]             grant_idx,
    output logic                      busy,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               abort_cnt
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [IW-1:0]         ptr;
    logic [WW-1:0]         wdog;
    logic [NUM_PORTS-1:0]  pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  acc;
    logic                  timeout;
    logic                  fwd_eof;
    byte_t                 sel_data;
    logic                  sel_eof;
    logic                  sel_err;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign pick_any = |pick_gnt;
    assign sel_data = req_data[grant_idx];
    assign sel_eof  = req_eof[grant_idx];
    assign sel_err  = req_err[grant_idx];

    // ready is purely state-driven, so valid never reaches ready
    assign acc     = (state != IDLE) && req_valid[grant_idx];
    assign timeout = (state == STREAM) && !acc
                   && (wdog == WW'(TIMEOUT_CYCLES - 1));
    assign fwd_eof = ((state == STREAM) && acc && sel_eof) || timeout;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: grant in IDLE, leave a frame on eof or watchdog.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_any) state_nxt = STREAM;
            end
            STREAM: begin
                if (acc && sel_eof) state_nxt = IDLE;
                else if (timeout)   state_nxt = DRAIN;
            end
            DRAIN: begin
                if (acc && sel_eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready only toward the owner of the current frame.
    always_comb begin
        req_ready = '0;
        if (state != IDLE) req_ready[grant_idx] = 1'b1;
    end

    // Grant and rr pointer; pointer starts at the top so port 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx <= '0;
            ptr       <= IW'(NUM_PORTS - 1);
        end else if ((state == IDLE) && pick_any) begin
            grant_idx <= pick_idx;
            ptr       <= pick_idx;
        end
    end

    // Watchdog: counts consecutive STREAM cycles without an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           wdog <= '0;
        else if ((state != STREAM) || acc) wdog <= '0;
        else                               wdog <= wdog + 1'b1;
    end

    // Registered parser beat: forwarded byte or synthetic abort beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eth_data_in    <= '0;
            eth_byte_valid <= 1'b0;
            eth_eof        <= 1'b0;
            eth_err        <= 1'b0;
        end else begin
            eth_byte_valid <= 1'b0;
            eth_eof        <= 1'b0;
            eth_err        <= 1'b0;
            if ((state == STREAM) && acc) begin
                eth_data_in    <= sel_data;
                eth_byte_valid <= 1'b1;
                eth_eof        <= sel_eof;
                eth_err        <= sel_eof & sel_err;
            end else if (timeout) begin
                eth_data_in    <= 8'h00;
                eth_byte_valid <= 1'b1;
                eth_eof        <= 1'b1;
                eth_err        <= 1'b1;
            end
        end
    end

`ifdef ARB_FRAME_STATS_EN
    // Frame and abort statistics, free-running 16-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (fwd_eof) frame_cnt <= frame_cnt + 16'd1;
            if (timeout) abort_cnt <= abort_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign abort_cnt = '0;
`endif

endmodule
